rv32i_dmem_if: RTL and testbench



---
 rtl/rv32i_dmem_if.sv | 239 +++++++++++++++++++++++
 tb/tb_rv32i_dmem_if.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem_if.sv
// rv32i_dmem_if: data-memory responder for the RV32I pipeline.
//
// Takes load/store requests from the execute stage (word-aligned address,
// pre-shifted byte enables and store data) and runs each one as a single
// transaction on an Avalon-MM-style master port. That port supports
// wait-states and pipelined read data. Load data is extracted, aligned and
// sign/zero-extended, then returned together with its destination register.
// The pipeline is held with stall while a transaction is outstanding.
// Misaligned accesses and transactions that exceed TIMEOUT_CYCLES pulse err.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   req_load, req_store    request strobes, sampled only while stall = 0
//   req_addr               word-aligned address
//   req_byte_off           original address bits [1:0]
//   req_width              0 byte, 1 half, 2/3 word
//   req_unsigned           zero-extend loads
//   req_be, req_wdata      lane-shifted store enables/data
//   req_rd                 load destination register
//   stall                  transaction in progress
//   ld_valid, ld_rd,       one-cycle load result pulse with register index
//   ld_data                and aligned, extended data
//   err                    one-cycle pulse on misalignment or timeout
//   avm_*                  Avalon-MM master port
module rv32i_dmem_if #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_byte_off,
   input  logic [1:0]  req_width,
   input  logic        req_unsigned,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        stall,
   output logic        ld_valid,
   output logic [4:0]  ld_rd,
   output logic [31:0] ld_data,
   output logic        err,
   output logic [31:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid
);

   typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_WAIT} state_t;

   // The last busy cycle allowed for a transaction has count TIMEOUT_CYCLES-1.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  width_q, width_d;
   logic        uns_q, uns_d;
   logic [4:0]  rd_q, rd_d;

   logic        ld_valid_d, err_d, avm_write_d, avm_read_d;
   logic [4:0]  ld_rd_d;
   logic [31:0] ld_data_d, avm_address_d, avm_writedata_d;
   logic [3:0]  avm_byteenable_d;

   logic        misaligned, timed_out, complete, abort;

   // Select the addressed lane and extend it to 32 bits.
   function automatic logic [31:0] align_load(input logic [31:0] d,
                                              input logic [1:0]  off,
                                              input logic [1:0]  width,
                                              input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (width)
         2'd0:    return {{24{~uns & b[7]}}, b};
         2'd1:    return {{16{~uns & h[15]}}, h};
         default: return d;  // width 3 behaves as word
      endcase
   endfunction

   assign stall      = (state_q != IDLE);
   assign misaligned = ((req_width == 2'd1) && req_byte_off[0]) ||
                       (req_width[1] && (req_byte_off != 2'd0));
   // The counter runs for the whole transaction, including READ_CMD -> READ_WAIT.
   assign timed_out  = (cnt_q == CNT_LAST);

   // NOTE: every signal assigned in this block gets a default first so that no path leaves it unassigned and infers a latch.
   always_comb begin
      state_d          = state_q;
      cnt_d            = stall ? cnt_q + 16'd1 : cnt_q;
      off_d            = off_q;
      width_d          = width_q;
      uns_d            = uns_q;
      rd_d             = rd_q;
      ld_valid_d       = 1'b0;
      err_d            = 1'b0;
      ld_rd_d          = ld_rd;
      ld_data_d        = ld_data;
      avm_address_d    = avm_address;
      avm_byteenable_d = avm_byteenable;
      avm_writedata_d  = avm_writedata;
      avm_write_d      = avm_write;
      avm_read_d       = avm_read;
      complete         = 1'b0;
      abort            = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_store) begin
               // A store wins over a simultaneous load.
               if (misaligned) begin
                  err_d = 1'b1;
               end else begin
                  avm_address_d    = req_addr;
                  avm_byteenable_d = req_be;
                  avm_writedata_d  = req_wdata;
                  avm_write_d      = 1'b1;
                  cnt_d            = 16'd0;
                  state_d          = WRITE;
               end
            end else if (req_load) begin
               if (misaligned) begin
                  err_d      = 1'b1;
                  ld_valid_d = 1'b1;
                  ld_rd_d    = req_rd;
                  ld_data_d  = 32'd0;
               end else begin
                  avm_address_d    = req_addr;
                  avm_byteenable_d = 4'b1111;
                  avm_read_d       = 1'b1;
                  off_d            = req_byte_off;
                  width_d          = req_width;
                  uns_d            = req_unsigned;
                  rd_d             = req_rd;
                  cnt_d            = 16'd0;
                  state_d          = READ_CMD;
               end
            end
         end
         WRITE: begin
            if (!avm_waitrequest) begin
               avm_write_d = 1'b0;
               state_d     = IDLE;
            end else if (timed_out) begin
               abort = 1'b1;
            end
         end
         READ_CMD: begin
            if (!avm_waitrequest && avm_readdatavalid) begin
               complete = 1'b1;
            end else if (timed_out) begin
               abort = 1'b1;
            end else if (!avm_waitrequest) begin
               avm_read_d = 1'b0;
               state_d    = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (avm_readdatavalid) begin
               complete = 1'b1;
            end else if (timed_out) begin
               abort = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (complete) begin
         avm_read_d = 1'b0;
         ld_valid_d = 1'b1;
         ld_rd_d    = rd_q;
         ld_data_d  = align_load(avm_readdata, off_q, width_q, uns_q);
         state_d    = IDLE;
      end

      if (abort) begin
         avm_read_d  = 1'b0;
         avm_write_d = 1'b0;
         err_d       = 1'b1;
         state_d     = IDLE;
         if (state_q != WRITE) begin
            ld_valid_d = 1'b1;
            ld_rd_d    = rd_q;
            ld_data_d  = 32'd0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         cnt_q          <= 16'd0;
         off_q          <= 2'd0;
         width_q        <= 2'd0;
         uns_q          <= 1'b0;
         rd_q           <= 5'd0;
         ld_valid       <= 1'b0;
         err            <= 1'b0;
         ld_rd          <= 5'd0;
         ld_data        <= 32'd0;
         avm_address    <= 32'd0;
         avm_byteenable <= 4'd0;
         avm_writedata  <= 32'd0;
         avm_write      <= 1'b0;
         avm_read       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         off_q          <= off_d;
         width_q        <= width_d;
         uns_q          <= uns_d;
         rd_q           <= rd_d;
         ld_valid       <= ld_valid_d;
         err            <= err_d;
         ld_rd          <= ld_rd_d;
         ld_data        <= ld_data_d;
         avm_address    <= avm_address_d;
         avm_byteenable <= avm_byteenable_d;
         avm_writedata  <= avm_writedata_d;
         avm_write      <= avm_write_d;
         avm_read       <= avm_read_d;
      end
   end

endmodule

// File: tb/tb_rv32i_dmem_if.sv
// tb_rv32i_dmem_if: self-checking bench for rv32i_dmem_if.
// Load results are predicted into a scoreboard queue when a load is issued
// and compared when ld_valid appears; each scenario task checks bus and
// handshake timing inline. Inputs and samples both happen on the falling edge.
module tb_rv32i_dmem_if;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_load, req_store, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_byte_off, req_width;
   logic [3:0]  req_be;
   logic [4:0]  req_rd;
   logic        stall, ld_valid, err;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic [3:0]  avm_byteenable;
   logic        avm_write, avm_read, avm_waitrequest, avm_readdatavalid;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
      logic        chk_rd;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   rv32i_dmem_if #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
      .req_byte_off(req_byte_off), .req_width(req_width),
      .req_unsigned(req_unsigned), .req_be(req_be), .req_wdata(req_wdata),
      .req_rd(req_rd), .stall(stall), .ld_valid(ld_valid), .ld_rd(ld_rd),
      .ld_data(ld_data), .err(err), .avm_address(avm_address),
      .avm_byteenable(avm_byteenable), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid)
   );

   // Scoreboard consumer: every ld_valid pulse must match the oldest prediction.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (ld_valid === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ld_valid: ld_data=%h ld_rd=%0d, no load outstanding", ld_data, ld_rd);
         end else begin
            e = sb.pop_front();
            if (ld_data !== e.data) begin
               miscompares++;
               $display("FAIL ld_data: got %h expected %h", ld_data, e.data);
            end
            if (e.chk_rd && ld_rd !== e.rd) begin
               miscompares++;
               $display("FAIL ld_rd: got %0d expected %0d", ld_rd, e.rd);
            end
            if (err !== e.err) begin
               miscompares++;
               $display("FAIL ld_err: got %b expected %b", err, e.err);
            end
         end
      end
   end

   task automatic expect_bit(input string name, input logic got, input logic want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, got, want);
      end
   endtask

   task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic idle_inputs();
      req_load = 1'b0; req_store = 1'b0; req_addr = 32'd0; req_byte_off = 2'd0;
      req_width = 2'd0; req_unsigned = 1'b0; req_be = 4'd0; req_wdata = 32'd0;
      req_rd = 5'd0; avm_waitrequest = 1'b0; avm_readdata = 32'd0;
      avm_readdatavalid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      expect_bit("rst_stall", stall, 1'b0);
      expect_bit("rst_ld_valid", ld_valid, 1'b0);
      expect_bit("rst_err", err, 1'b0);
      expect_bit("rst_avm_read", avm_read, 1'b0);
      expect_bit("rst_avm_write", avm_write, 1'b0);
      expect_word("rst_ld_rd", {27'd0, ld_rd}, 32'd0);
      expect_word("rst_ld_data", ld_data, 32'd0);
      expect_word("rst_avm_address", avm_address, 32'd0);
      expect_word("rst_avm_be", {28'd0, avm_byteenable}, 32'd0);
      expect_word("rst_avm_wdata", avm_writedata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Zero-wait byte load: avm_read in T+1, data in T+2, ld_valid in T+3.
   task automatic test_byte_load(input logic uns, input logic [31:0] want);
      req_load = 1'b1; req_addr = 32'h100; req_byte_off = 2'd2; req_width = 2'd0;
      req_unsigned = uns; req_rd = 5'd5; avm_waitrequest = 1'b0;
      sb.push_back('{rd: 5'd5, data: want, err: 1'b0, chk_rd: 1'b1});
      @(negedge clk);  // T+1
      req_load = 1'b0;
      expect_bit("byte_read_t1", avm_read, 1'b1);
      expect_bit("byte_stall_t1", stall, 1'b1);
      expect_word("byte_addr", avm_address, 32'h100);
      expect_word("byte_be", {28'd0, avm_byteenable}, 32'hF);
      @(negedge clk);  // T+2
      expect_bit("byte_read_t2", avm_read, 1'b0);
      expect_bit("byte_stall_t2", stall, 1'b1);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h12803456;
      @(negedge clk);  // T+3
      avm_readdatavalid = 1'b0;
      expect_bit("byte_ld_valid_t3", ld_valid, 1'b1);
      expect_bit("byte_stall_t3", stall, 1'b0);
      @(negedge clk);
      expect_bit("byte_ld_valid_pulse", ld_valid, 1'b0);
   endtask

   task automatic test_store_wait();
      req_store = 1'b1; req_addr = 32'h200; req_byte_off = 2'd2; req_width = 2'd1;
      req_be = 4'b1100; req_wdata = 32'hBEEF0000; avm_waitrequest = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         req_store = 1'b0;
         expect_bit("st_write", avm_write, 1'b1);
         expect_bit("st_stall", stall, 1'b1);
         expect_word("st_addr", avm_address, 32'h200);
         expect_word("st_be", {28'd0, avm_byteenable}, 32'hC);
         expect_word("st_wdata", avm_writedata, 32'hBEEF0000);
         if (c == 4) avm_waitrequest = 1'b0;
      end
      @(negedge clk);
      expect_bit("st_write_done", avm_write, 1'b0);
      expect_bit("st_stall_done", stall, 1'b0);
   endtask

   // Word load: command held 3 cycles, data 4 cycles after command accept,
   // while new requests are waved at the stalled interface.
   task automatic test_back_to_back();
      req_load = 1'b1; req_addr = 32'h300; req_byte_off = 2'd0; req_width = 2'd2;
      req_unsigned = 1'b0; req_rd = 5'd12; avm_waitrequest = 1'b1;
      req_be = 4'b1111; req_wdata = 32'h55AA55AA;
      sb.push_back('{rd: 5'd12, data: 32'hCAFEF00D, err: 1'b0, chk_rd: 1'b1});
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         expect_bit("b2b_read", avm_read, (c <= 3));
         expect_bit("b2b_write", avm_write, 1'b0);
         expect_bit("b2b_stall", stall, (c <= 7));
         if (c == 8) expect_bit("b2b_ld_valid", ld_valid, 1'b1);
         req_load  = (c <= 5) && (c % 2 == 1);
         req_store = (c <= 5) && (c % 2 == 0);
         req_addr  = 32'h380 + 32'(c * 4);
         if (c == 3) avm_waitrequest = 1'b0;
         avm_readdatavalid = (c == 7);
         avm_readdata      = (c == 7) ? 32'hCAFEF00D : 32'h0;
      end
   endtask

   task automatic test_misaligned();
      req_load = 1'b1; req_addr = 32'h104; req_byte_off = 2'd1; req_width = 2'd1;
      req_rd = 5'd7; avm_waitrequest = 1'b0;
      sb.push_back('{rd: 5'd7, data: 32'd0, err: 1'b1, chk_rd: 1'b0});
      @(negedge clk);
      req_load = 1'b0;
      expect_bit("mis_err", err, 1'b1);
      expect_bit("mis_ld_valid", ld_valid, 1'b1);
      expect_bit("mis_read", avm_read, 1'b0);
      expect_bit("mis_stall", stall, 1'b0);
      @(negedge clk);
      expect_bit("mis_err_pulse", err, 1'b0);
      expect_bit("mis_read_after", avm_read, 1'b0);
   endtask

   task automatic test_timeout();
      req_load = 1'b1; req_addr = 32'h500; req_byte_off = 2'd0; req_width = 2'd2;
      req_rd = 5'd9; avm_waitrequest = 1'b0;
      sb.push_back('{rd: 5'd9, data: 32'd0, err: 1'b1, chk_rd: 1'b0});
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         req_load = 1'b0;
         expect_bit("tmo_stall", stall, (c <= 8));
         expect_bit("tmo_read", avm_read, (c == 1));
         expect_bit("tmo_err", err, (c == 9));
         expect_bit("tmo_ld_valid", ld_valid, (c == 9));
      end
   endtask

   task automatic test_store_wins();
      req_load = 1'b1; req_store = 1'b1; req_addr = 32'h400; req_byte_off = 2'd0;
      req_width = 2'd1; req_be = 4'b0011; req_wdata = 32'h00001234; req_rd = 5'd3;
      avm_waitrequest = 1'b0;
      @(negedge clk);
      req_load = 1'b0; req_store = 1'b0;
      expect_bit("both_write", avm_write, 1'b1);
      expect_bit("both_read", avm_read, 1'b0);
      expect_word("both_addr", avm_address, 32'h400);
      expect_word("both_wdata", avm_writedata, 32'h00001234);
      @(negedge clk);
      expect_bit("both_write_end", avm_write, 1'b0);
      expect_bit("both_read_end", avm_read, 1'b0);
      expect_bit("both_stall_end", stall, 1'b0);
   endtask

   task automatic test_reset_mid_read();
      req_load = 1'b1; req_addr = 32'h600; req_byte_off = 2'd0; req_width = 2'd2;
      req_rd = 5'd14; avm_waitrequest = 1'b0;
      @(negedge clk);  // T+1: READ_CMD
      req_load = 1'b0;
      @(negedge clk);  // T+2: READ_WAIT
      expect_bit("mid_stall", stall, 1'b1);
      reset_n = 1'b0;
      @(negedge clk);
      expect_bit("mid_rst_stall", stall, 1'b0);
      expect_bit("mid_rst_read", avm_read, 1'b0);
      expect_word("mid_rst_addr", avm_address, 32'd0);
      expect_word("mid_rst_be", {28'd0, avm_byteenable}, 32'd0);
      reset_n = 1'b1;
      avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      expect_bit("mid_late_ld_valid", ld_valid, 1'b0);
      @(negedge clk);
      expect_bit("mid_late_ld_valid2", ld_valid, 1'b0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_byte_load(1'b0, 32'hFFFFFF80);
      test_byte_load(1'b1, 32'h00000080);
      test_store_wait();
      test_back_to_back();
      test_misaligned();
      test_timeout();
      test_store_wins();
      test_reset_mid_read();
      repeat (2) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d loads never returned", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
